// File: rtl/residual_add_par.sv
// Residual add y = x + (sub >>> shift), LANES elements per cycle, optional saturation.
// Latency: N/LANES+1 cycles from start-sample to done; start is ignored while busy (no backpressure).
// Inputs must stay stable for the whole pass; results and overflow count hold until the next start.
module residual_add_par #(
    parameter  int DATA_WIDTH = 16,
    parameter  int SEQ_LEN    = 8,
    parameter  int EMB_DIM    = 8,
    parameter  int LANES      = 4,
    parameter  int MAX_SHIFT  = 7,
    localparam int N          = SEQ_LEN * EMB_DIM,
    localparam int SHW        = $clog2(MAX_SHIFT + 1),
    localparam int OVW        = $clog2(N + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    sat_en,
    input  logic [SHW-1:0]          sub_shift,
    input  logic [DATA_WIDTH*N-1:0] x_in,
    input  logic [DATA_WIDTH*N-1:0] sub_in,
    output logic [DATA_WIDTH*N-1:0] y_out,
    output logic                    busy,
    output logic                    done,
    output logic                    out_valid,
    output logic [OVW-1:0]          ovf_count
);
    localparam int GROUPS = N / ((LANES < 1) ? 1 : LANES);
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [DATA_WIDTH-1:0] MAX_VAL = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    generate
        if ((LANES < 1) || ((N % ((LANES < 1) ? 1 : LANES)) != 0)) begin : g_bad_lanes
            $error("residual_add_par: LANES must be >= 1 and divide SEQ_LEN*EMB_DIM");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t                state;
    logic [GW-1:0]         grp;
    logic                  sat_q;
    logic [SHW-1:0]        shift_q;
    logic [SHW-1:0]        shift_clamp;
    logic [OVW-1:0]        ovf_q;
    logic                  vld_q;
    logic [OVW-1:0]        lane_cnt;
    logic [DATA_WIDTH-1:0] lane_y [LANES];
    logic [DATA_WIDTH-1:0] y_q    [N];

    assign shift_clamp = (int'(sub_shift) > MAX_SHIFT) ? SHW'(MAX_SHIFT) : sub_shift;

    // Sum is formed one bit wider so overflow shows up as disagreement of the top two bits.
    always_comb begin : lane_math
        logic signed [DATA_WIDTH-1:0] xv;
        logic signed [DATA_WIDTH-1:0] sv;
        logic signed [DATA_WIDTH-1:0] shd;
        logic        [DATA_WIDTH:0]   sum;
        logic                         ovf;
        int                           idx;
        lane_cnt = '0;
        lane_y   = '{default: '0};
        xv       = '0;
        sv       = '0;
        shd      = '0;
        sum      = '0;
        ovf      = 1'b0;
        idx      = 0;
        for (int l = 0; l < LANES; l++) begin
            idx = int'(grp) * LANES + l;
            xv  = x_in[idx*DATA_WIDTH +: DATA_WIDTH];
            sv  = sub_in[idx*DATA_WIDTH +: DATA_WIDTH];
            shd = sv >>> shift_q;
            sum = {xv[DATA_WIDTH-1], xv} + {shd[DATA_WIDTH-1], shd};
            ovf = sum[DATA_WIDTH] ^ sum[DATA_WIDTH-1];
            if (ovf && sat_q)
                lane_y[l] = sum[DATA_WIDTH] ? MIN_VAL : MAX_VAL;
            else
                lane_y[l] = sum[DATA_WIDTH-1:0];
            lane_cnt = lane_cnt + OVW'(ovf);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            grp     <= '0;
            sat_q   <= 1'b0;
            shift_q <= '0;
            ovf_q   <= '0;
            vld_q   <= 1'b0;
            for (int i = 0; i < N; i++) y_q[i] <= '0;
        end else begin
            case (state)
                ADD: begin
                    for (int l = 0; l < LANES; l++) y_q[int'(grp) * LANES + l] <= lane_y[l];
                    ovf_q <= ovf_q + lane_cnt;
                    if (grp == GW'(GROUPS - 1)) begin
                        state <= DONE;
                        vld_q <= 1'b1;
                    end else begin
                        grp <= grp + 1'b1;
                    end
                end
                IDLE, DONE: begin
                    if (start) begin
                        state   <= ADD;
                        grp     <= '0;
                        ovf_q   <= '0;
                        vld_q   <= 1'b0;
                        sat_q   <= sat_en;
                        shift_q <= shift_clamp;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    generate
        for (genvar i = 0; i < N; i++) begin : g_pack
            assign y_out[i*DATA_WIDTH +: DATA_WIDTH] = y_q[i];
        end
    endgenerate

    assign busy      = (state == ADD);
    assign done      = (state == DONE);
    assign out_valid = vld_q;
    assign ovf_count = ovf_q;

endmodule

// File: tb/tb_residual_add_par.sv
// Bench for residual_add_par: directed corner cases on the default build, random passes on LANES=1/4/8 builds.
module tb_residual_add_par;
    localparam int DW  = 16;
    localparam int N   = 64;
    localparam int OVW = 7;
    localparam int LAT = 17;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          sat_en = 1'b0;
    logic [2:0]    sub_shift = '0;
    logic [DW*N-1:0] x_in = '0;
    logic [DW*N-1:0] sub_in = '0;

    logic [DW*N-1:0] y4, y1, y8;
    logic            busy4, busy1, busy8;
    logic            done4, done1, done8;
    logic            valid4, valid1, valid8;
    logic [OVW-1:0]  ovf4, ovf1, ovf8;

    int errors = 0;
    int checks = 0;
    logic [DW*N-1:0] exp_y;
    int              exp_ovf;

    residual_add_par u_l4 (
        .clk(clk), .rst_n(rst_n), .start(start), .sat_en(sat_en), .sub_shift(sub_shift),
        .x_in(x_in), .sub_in(sub_in), .y_out(y4), .busy(busy4), .done(done4),
        .out_valid(valid4), .ovf_count(ovf4)
    );
    residual_add_par #(.LANES(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .start(start), .sat_en(sat_en), .sub_shift(sub_shift),
        .x_in(x_in), .sub_in(sub_in), .y_out(y1), .busy(busy1), .done(done1),
        .out_valid(valid1), .ovf_count(ovf1)
    );
    residual_add_par #(.LANES(8)) u_l8 (
        .clk(clk), .rst_n(rst_n), .start(start), .sat_en(sat_en), .sub_shift(sub_shift),
        .x_in(x_in), .sub_in(sub_in), .y_out(y8), .busy(busy8), .done(done8),
        .out_valid(valid8), .ovf_count(ovf8)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Element-wise reference from the arithmetic definition using plain integers.
    task automatic model();
        int xv, sv, s, r;
        logic [15:0] ex, es;
        exp_ovf = 0;
        exp_y   = '0;
        for (int i = 0; i < N; i++) begin
            ex = x_in[i*DW +: DW];
            es = sub_in[i*DW +: DW];
            xv = $signed(ex);
            sv = $signed(es);
            sv = sv >>> sub_shift;
            s  = xv + sv;
            r  = s;
            if (s > 32767 || s < -32768) begin
                exp_ovf++;
                if (sat_en) r = (s > 0) ? 32767 : -32768;
            end
            exp_y[i*DW +: DW] = r[15:0];
        end
    endtask

    function automatic int first_diff(input logic [DW*N-1:0] a, input logic [DW*N-1:0] b);
        for (int i = 0; i < N; i++)
            if (a[i*DW +: DW] !== b[i*DW +: DW]) return i;
        return 0;
    endfunction

    task automatic fill(input logic [15:0] xv, input logic [15:0] sv);
        for (int i = 0; i < N; i++) begin
            x_in[i*DW +: DW]   = xv;
            sub_in[i*DW +: DW] = sv;
        end
    endtask

    // Pulses start for one sampling edge and counts edges (sampling edge included) until done.
    task automatic run_pass(output int cycles);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        cycles = 1;
        while (done4 !== 1'b1 && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (done4 !== 1'b1) cycles = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (y4 !== '0) begin errors++; $display("FAIL reset_y elem %0d got %h want 0000", first_diff(y4, '0), y4[first_diff(y4, '0)*DW +: DW]); end
        checks++; if (ovf4 !== '0) begin errors++; $display("FAIL reset_ovf got %0d want 0", ovf4); end
        checks++; if ({busy4, done4, valid4} !== 3'b000) begin errors++; $display("FAIL reset_flags busy/done/valid got %b want 000", {busy4, done4, valid4}); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_idle busy got %b want 0", busy4); end
    endtask

    task automatic test_sat_basic();
        int c;
        fill(16'h4000, 16'h4000);
        sat_en = 1'b1; sub_shift = 3'd0;
        exp_y = {N{16'h7FFF}};
        run_pass(c);
        checks++; if (c != LAT) begin errors++; $display("FAIL sat_latency got %0d want %0d", c, LAT); end
        checks++; if (y4 !== exp_y) begin errors++; $display("FAIL sat_y elem %0d got %h want 7fff", first_diff(y4, exp_y), y4[first_diff(y4, exp_y)*DW +: DW]); end
        checks++; if (ovf4 !== 7'd64) begin errors++; $display("FAIL sat_ovf got %0d want 64", ovf4); end
        checks++; if (valid4 !== 1'b1) begin errors++; $display("FAIL sat_valid got %b want 1", valid4); end
        @(posedge clk); #1;
        checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL done_width done got %b want 0", done4); end
        repeat (3) @(posedge clk); #1;
        checks++; if (valid4 !== 1'b1 || y4 !== exp_y || ovf4 !== 7'd64) begin errors++; $display("FAIL hold valid=%b ovf=%0d want valid=1 ovf=64 and y stable", valid4, ovf4); end
    endtask

    task automatic test_wrap();
        int c;
        fill(16'h4000, 16'h4000);
        sat_en = 1'b0; sub_shift = 3'd0;
        exp_y = {N{16'h8000}};
        run_pass(c);
        checks++; if (y4 !== exp_y) begin errors++; $display("FAIL wrap_y elem %0d got %h want 8000", first_diff(y4, exp_y), y4[first_diff(y4, exp_y)*DW +: DW]); end
        checks++; if (ovf4 !== 7'd64) begin errors++; $display("FAIL wrap_ovf got %0d want 64", ovf4); end
    endtask

    task automatic test_shift_neg();
        int c;
        fill(16'h2000, 16'h8000);
        sat_en = 1'b1; sub_shift = 3'd1;
        exp_y = {N{16'hE000}};
        run_pass(c);
        checks++; if (y4 !== exp_y) begin errors++; $display("FAIL shift_y elem %0d got %h want e000", first_diff(y4, exp_y), y4[first_diff(y4, exp_y)*DW +: DW]); end
        checks++; if (ovf4 !== 7'd0) begin errors++; $display("FAIL shift_ovf got %0d want 0", ovf4); end
        fill(16'h8000, 16'hFFFF);
        sub_shift = 3'd0;
        for (int m = 1; m >= 0; m--) begin
            sat_en = m[0];
            exp_y  = m[0] ? {N{16'h8000}} : {N{16'h7FFF}};
            run_pass(c);
            checks++; if (y4 !== exp_y) begin errors++; $display("FAIL negovf_y sat=%0d elem %0d got %h want %h", m, first_diff(y4, exp_y), y4[first_diff(y4, exp_y)*DW +: DW], exp_y[15:0]); end
            checks++; if (ovf4 !== 7'd64) begin errors++; $display("FAIL negovf_ovf sat=%0d got %0d want 64", m, ovf4); end
        end
    endtask

    task automatic test_back_to_back();
        int c, pulses, lat;
        bit early_valid;
        fill(16'h4000, 16'h4000);
        sat_en = 1'b1; sub_shift = 3'd0;
        run_pass(c);
        checks++; if (c != LAT) begin errors++; $display("FAIL b2b_first_latency got %0d want %0d", c, LAT); end
        // Still inside the DONE cycle: request the next pass immediately.
        fill(16'h1000, 16'h2000);
        sat_en = 1'b0;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if ({busy4, done4, valid4} !== 3'b100) begin errors++; $display("FAIL b2b_enter busy/done/valid got %b want 100", {busy4, done4, valid4}); end
        pulses = 0; lat = -1; early_valid = 1'b0;
        for (int cyc = 2; cyc <= 40; cyc++) begin
            if (cyc == 6) begin start = 1'b1; sub_shift = 3'd7; sat_en = 1'b1; end
            if (cyc == 7) begin start = 1'b0; sub_shift = 3'd0; sat_en = 1'b0; end
            @(posedge clk); #1;
            if (done4 === 1'b1) begin pulses++; if (lat < 0) lat = cyc; end
            if (lat < 0 && valid4 === 1'b1) early_valid = 1'b1;
        end
        checks++; if (lat != LAT) begin errors++; $display("FAIL b2b_second_latency got %0d want %0d", lat, LAT); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL b2b_done_pulses got %0d want 1", pulses); end
        checks++; if (early_valid) begin errors++; $display("FAIL b2b_valid_during_pass got 1 want 0"); end
        exp_y = {N{16'h3000}};
        checks++; if (y4 !== exp_y) begin errors++; $display("FAIL b2b_y elem %0d got %h want 3000", first_diff(y4, exp_y), y4[first_diff(y4, exp_y)*DW +: DW]); end
        checks++; if (ovf4 !== 7'd0) begin errors++; $display("FAIL b2b_ovf got %0d want 0", ovf4); end
    endtask

    task automatic test_reset_mid();
        int c;
        fill(16'h4000, 16'h4000);
        sat_en = 1'b1; sub_shift = 3'd0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (y4 !== '0) begin errors++; $display("FAIL midreset_y elem %0d got %h want 0000", first_diff(y4, '0), y4[first_diff(y4, '0)*DW +: DW]); end
        checks++; if (ovf4 !== '0 || {busy4, done4, valid4} !== 3'b000) begin errors++; $display("FAIL midreset_flags ovf=%0d bdv=%b want 0 000", ovf4, {busy4, done4, valid4}); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk); #1;
        checks++; if (busy4 !== 1'b0 || valid4 !== 1'b0) begin errors++; $display("FAIL no_resume busy=%b valid=%b want 0 0", busy4, valid4); end
        fill(16'h0100, 16'h0200);
        sat_en = 1'b0; sub_shift = 3'd1;
        model();
        run_pass(c);
        checks++; if (c != LAT) begin errors++; $display("FAIL post_reset_latency got %0d want %0d", c, LAT); end
        checks++; if (y4 !== exp_y || ovf4 !== 7'(exp_ovf)) begin errors++; $display("FAIL post_reset_pass elem %0d got %h want %h ovf %0d want %0d", first_diff(y4, exp_y), y4[first_diff(y4, exp_y)*DW +: DW], exp_y[first_diff(y4, exp_y)*DW +: DW], ovf4, exp_ovf); end
    endtask

    task automatic test_random(input int iters);
        int wait_cyc;
        logic [15:0] v;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int it = 0; it < iters; it++) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < 2; k++) begin
                    case ($urandom_range(0, 3))
                        0: v = 16'($urandom);
                        1: v = {2'b01, 14'($urandom)};
                        2: v = {2'b10, 14'($urandom)};
                        default: v = $urandom_range(0, 1) ? 16'h7FFF : 16'h8000;
                    endcase
                    if (k == 0) x_in[i*DW +: DW] = v; else sub_in[i*DW +: DW] = v;
                end
            end
            sat_en    = 1'($urandom_range(0, 1));
            sub_shift = 3'($urandom_range(0, 7));
            model();
            @(negedge clk);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            wait_cyc = 0;
            while (!(valid4 === 1'b1 && valid1 === 1'b1 && valid8 === 1'b1) && wait_cyc < 200) begin
                @(posedge clk); #1;
                wait_cyc++;
            end
            checks++; if (wait_cyc >= 200) begin errors++; $display("FAIL rand_timeout iter %0d valid l4/l1/l8 = %b%b%b want 111", it, valid4, valid1, valid8); end
            checks++; if (y4 !== exp_y) begin errors++; $display("FAIL rand_y_l4 iter %0d elem %0d got %h want %h", it, first_diff(y4, exp_y), y4[first_diff(y4, exp_y)*DW +: DW], exp_y[first_diff(y4, exp_y)*DW +: DW]); end
            checks++; if (y1 !== exp_y) begin errors++; $display("FAIL rand_y_l1 iter %0d elem %0d got %h want %h", it, first_diff(y1, exp_y), y1[first_diff(y1, exp_y)*DW +: DW], exp_y[first_diff(y1, exp_y)*DW +: DW]); end
            checks++; if (y8 !== exp_y) begin errors++; $display("FAIL rand_y_l8 iter %0d elem %0d got %h want %h", it, first_diff(y8, exp_y), y8[first_diff(y8, exp_y)*DW +: DW], exp_y[first_diff(y8, exp_y)*DW +: DW]); end
            checks++; if (ovf4 !== 7'(exp_ovf)) begin errors++; $display("FAIL rand_ovf_l4 iter %0d got %0d want %0d", it, ovf4, exp_ovf); end
            checks++; if (ovf1 !== 7'(exp_ovf)) begin errors++; $display("FAIL rand_ovf_l1 iter %0d got %0d want %0d", it, ovf1, exp_ovf); end
            checks++; if (ovf8 !== 7'(exp_ovf)) begin errors++; $display("FAIL rand_ovf_l8 iter %0d got %0d want %0d", it, ovf8, exp_ovf); end
        end
    endtask

    initial begin
        test_reset();
        test_sat_basic();
        test_wrap();
        test_shift_neg();
        test_back_to_back();
        test_reset_mid();
        test_random(8);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
